// File: rtl/jump_verify.sv
// jump_verify: verifies jump-stack return-address predictions against
// resolved jr targets, per thread.
//
// Each of the 4 threads owns a small FIFO of predicted targets. Predictions
// are pushed as they leave pre-align. When a jr resolves in execute, the
// actual target is compared with the oldest pending prediction for that
// thread.
//   - Hit:  the head is popped.
//   - Miss: the FIFO is flushed and a registered redirect is issued. The
//           thread then spends one cycle in SQUASH, during which its
//           (wrong-path) predictions are dropped.
// Hit and miss totals are kept as saturating counters.
//
// Ports:
//   i_Clk, i_Reset        clock (rising edge); asynchronous active-high reset
//   i_Stall               blocks prediction enqueue (resolve is unaffected)
//   i_pred_*              incoming prediction: valid, thread, address
//   i_resolve_*           resolving jr: valid, thread, actual target
//   o_redirect*           one-cycle refetch pulse with thread and target
//   o_full                per-thread FIFO-full flags
//   o_overflow            pulse: a prediction was dropped on a full FIFO
//   o_hit_count           saturating count of correct predictions
//   o_miss_count          saturating count of mispredictions
module jump_verify #(
  parameter int ADDRESS_WIDTH = 22,
  parameter int DEPTH         = 4
) (
  input  logic                     i_Clk,
  input  logic                     i_Reset,
  input  logic                     i_Stall,
  input  logic                     i_pred_valid,
  input  logic [1:0]               i_pred_thread,
  input  logic [ADDRESS_WIDTH-1:0] i_pred_address,
  input  logic                     i_resolve_valid,
  input  logic [1:0]               i_resolve_thread,
  input  logic [ADDRESS_WIDTH-1:0] i_resolve_target,
  output logic                     o_redirect,
  output logic [1:0]               o_redirect_thread,
  output logic [ADDRESS_WIDTH-1:0] o_redirect_address,
  output logic [3:0]               o_full,
  output logic                     o_overflow,
  output logic [15:0]              o_hit_count,
  output logic [15:0]              o_miss_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic {ACTIVE = 1'b0, SQUASH = 1'b1} state_t;

  logic [ADDRESS_WIDTH-1:0] mem   [4][DEPTH];
  logic [PW-1:0]            head  [4];
  logic [PW-1:0]            tail  [4];
  logic [CW-1:0]            count [4];
  state_t                   state [4];

  logic [ADDRESS_WIDTH-1:0] head_data;
  logic                     same_thread;
  logic                     res_hit;
  logic                     res_miss;
  logic                     pred_take;
  logic                     pred_room;
  logic                     push;
  logic                     drop;

  always_comb begin
    head_data   = mem[i_resolve_thread][head[i_resolve_thread]];
    same_thread = (i_resolve_thread == i_pred_thread);
    res_hit     = i_resolve_valid && (count[i_resolve_thread] != '0) &&
                  (head_data == i_resolve_target);
    res_miss    = i_resolve_valid && !res_hit;
    // A miss on the same thread flushes the FIFO, so the incoming prediction
    // is discarded rather than pushed or counted as an overflow.
    pred_take   = i_pred_valid && !i_Stall &&
                  (state[i_pred_thread] == ACTIVE) &&
                  !(res_miss && same_thread);
    // A same-cycle hit pops the head, freeing a slot for the push.
    pred_room   = (count[i_pred_thread] != FULL_CNT) ||
                  (res_hit && same_thread);
    push        = pred_take && pred_room;
    drop        = pred_take && !pred_room;
  end

  always_comb begin
    o_full = '0;
    for (int unsigned t = 0; t < 4; t++) begin
      o_full[t] = (count[t] == FULL_CNT);
    end
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      for (int unsigned t = 0; t < 4; t++) begin
        head[t]  <= '0;
        tail[t]  <= '0;
        count[t] <= '0;
        state[t] <= ACTIVE;
        for (int unsigned d = 0; d < DEPTH; d++) begin
          mem[t][d] <= '0;
        end
      end
      o_redirect         <= 1'b0;
      o_redirect_thread  <= '0;
      o_redirect_address <= '0;
      o_overflow         <= 1'b0;
      o_hit_count        <= '0;
      o_miss_count       <= '0;
    end else begin
      for (int unsigned t = 0; t < 4; t++) begin
        logic push_t;
        logic pop_t;
        push_t = push && (i_pred_thread == 2'(t));
        pop_t  = res_hit && (i_resolve_thread == 2'(t));

        if (res_miss && (i_resolve_thread == 2'(t))) begin
          head[t]  <= '0;
          tail[t]  <= '0;
          count[t] <= '0;
          state[t] <= SQUASH;
        end else begin
          // SQUASH lasts exactly one cycle.
          state[t] <= ACTIVE;
          if (pop_t) begin
            head[t] <= head[t] + 1'b1;
          end
          if (push_t) begin
            mem[t][tail[t]] <= i_pred_address;
            tail[t]         <= tail[t] + 1'b1;
          end
          if (push_t && !pop_t) begin
            count[t] <= count[t] + 1'b1;
          end else if (pop_t && !push_t) begin
            count[t] <= count[t] - 1'b1;
          end
        end
      end

      o_redirect <= res_miss;
      if (res_miss) begin
        o_redirect_thread  <= i_resolve_thread;
        o_redirect_address <= i_resolve_target;
      end
      o_overflow <= drop;

      if (res_hit && (o_hit_count != '1)) begin
        o_hit_count <= o_hit_count + 1'b1;
      end
      if (res_miss && (o_miss_count != '1)) begin
        o_miss_count <= o_miss_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_jump_verify.sv
// Directed testbench for jump_verify (ADDRESS_WIDTH=22, DEPTH=4).
// Inputs change 1 time unit after a rising edge; registered outputs are
// sampled at the same point after the following edge.
module tb_jump_verify;

  localparam int AW = 22;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          stall = 1'b0;
  logic          pred_valid = 1'b0;
  logic [1:0]    pred_thread = '0;
  logic [AW-1:0] pred_address = '0;
  logic          resolve_valid = 1'b0;
  logic [1:0]    resolve_thread = '0;
  logic [AW-1:0] resolve_target = '0;
  logic          redirect;
  logic [1:0]    redirect_thread;
  logic [AW-1:0] redirect_address;
  logic [3:0]    full;
  logic          overflow;
  logic [15:0]   hit_count;
  logic [15:0]   miss_count;

  int tests  = 0;
  int failed = 0;

  jump_verify #(.ADDRESS_WIDTH(AW), .DEPTH(4)) dut (
    .i_Clk              (clk),
    .i_Reset            (rst),
    .i_Stall            (stall),
    .i_pred_valid       (pred_valid),
    .i_pred_thread      (pred_thread),
    .i_pred_address     (pred_address),
    .i_resolve_valid    (resolve_valid),
    .i_resolve_thread   (resolve_thread),
    .i_resolve_target   (resolve_target),
    .o_redirect         (redirect),
    .o_redirect_thread  (redirect_thread),
    .o_redirect_address (redirect_address),
    .o_full             (full),
    .o_overflow         (overflow),
    .o_hit_count        (hit_count),
    .o_miss_count       (miss_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pred_valid    = 1'b0;
    resolve_valid = 1'b0;
    stall         = 1'b0;
  endtask

  task automatic set_pred(input logic [1:0] t, input logic [AW-1:0] a);
    pred_valid = 1'b1; pred_thread = t; pred_address = a;
  endtask

  task automatic set_res(input logic [1:0] t, input logic [AW-1:0] a);
    resolve_valid = 1'b1; resolve_thread = t; resolve_target = a;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tests++;
    if ({redirect, redirect_thread, redirect_address, full, overflow, hit_count, miss_count} !== '0) begin
      failed++;
      $display("FAIL reset_outputs: got red=%b thr=%0d addr=%h full=%b ovf=%b hit=%0d miss=%0d, expected all 0",
               redirect, redirect_thread, redirect_address, full, overflow, hit_count, miss_count);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_hit();
    set_pred(2'd0, 22'h00100);
    tick();
    idle();
    set_res(2'd0, 22'h00100);
    tick();
    idle();
    tests++;
    if ({redirect, hit_count, miss_count, full} !== {1'b0, 16'd1, 16'd0, 4'b0000}) begin
      failed++;
      $display("FAIL basic_hit: got red=%b hit=%0d miss=%0d full=%b, expected red=0 hit=1 miss=0 full=0000",
               redirect, hit_count, miss_count, full);
    end
    // Same target again must miss if thread 0 really was emptied.
    set_res(2'd0, 22'h00100);
    tick();
    idle();
    tests++;
    if ({redirect, redirect_thread, redirect_address, miss_count} !== {1'b1, 2'd0, 22'h00100, 16'd1}) begin
      failed++;
      $display("FAIL basic_hit_empty: got red=%b thr=%0d addr=%h miss=%0d, expected red=1 thr=0 addr=000100 miss=1",
               redirect, redirect_thread, redirect_address, miss_count);
    end
    tick();
    tests++;
    if (redirect !== 1'b0) begin
      failed++;
      $display("FAIL redirect_pulse: got red=%b, expected 0", redirect);
    end
  endtask

  task automatic test_mismatch();
    set_pred(2'd2, 22'h0A); tick();
    set_pred(2'd2, 22'h0B); tick();
    set_pred(2'd2, 22'h0C); tick();
    idle();
    set_res(2'd2, 22'h0F);
    tick();
    idle();
    tests++;
    if ({redirect, redirect_thread, redirect_address, miss_count} !== {1'b1, 2'd2, 22'h0F, 16'd2}) begin
      failed++;
      $display("FAIL mismatch_redirect: got red=%b thr=%0d addr=%h miss=%0d, expected red=1 thr=2 addr=00000f miss=2",
               redirect, redirect_thread, redirect_address, miss_count);
    end
    // Wrong-path prediction in the redirect cycle.
    set_pred(2'd2, 22'h55);
    tick();
    idle();
    tests++;
    if (redirect !== 1'b0) begin
      failed++;
      $display("FAIL mismatch_pulse: got red=%b, expected 0", redirect);
    end
    // Would hit if 0x55 had been queued; must miss on an empty FIFO.
    set_res(2'd2, 22'h55);
    tick();
    idle();
    tests++;
    if ({redirect, redirect_thread, hit_count, miss_count} !== {1'b1, 2'd2, 16'd1, 16'd3}) begin
      failed++;
      $display("FAIL squash_drop: got red=%b thr=%0d hit=%0d miss=%0d, expected red=1 thr=2 hit=1 miss=3",
               redirect, redirect_thread, hit_count, miss_count);
    end
    tick();
  endtask

  task automatic test_full_overflow();
    for (int i = 0; i < 4; i++) begin
      set_pred(2'd1, 22'h11 + AW'(i));
      tick();
    end
    tests++;
    if ({full, overflow} !== {4'b0010, 1'b0}) begin
      failed++;
      $display("FAIL full_flag: got full=%b ovf=%b, expected full=0010 ovf=0", full, overflow);
    end
    set_pred(2'd1, 22'h15);
    tick();
    idle();
    tests++;
    if ({full, overflow} !== {4'b0010, 1'b1}) begin
      failed++;
      $display("FAIL overflow_pulse: got full=%b ovf=%b, expected full=0010 ovf=1", full, overflow);
    end
    tick();
    tests++;
    if (overflow !== 1'b0) begin
      failed++;
      $display("FAIL overflow_clear: got ovf=%b, expected 0", overflow);
    end
    for (int i = 0; i < 4; i++) begin
      set_res(2'd1, 22'h11 + AW'(i));
      tick();
      tests++;
      if ({redirect, hit_count} !== {1'b0, 16'(2 + i)}) begin
        failed++;
        $display("FAIL drain_hit%0d: got red=%b hit=%0d, expected red=0 hit=%0d", i, redirect, hit_count, 2 + i);
      end
    end
    idle();
    tests++;
    if ({full, miss_count} !== {4'b0000, 16'd3}) begin
      failed++;
      $display("FAIL drain_empty: got full=%b miss=%0d, expected full=0000 miss=3", full, miss_count);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      set_pred(2'd3, 22'h31 + AW'(i));
      tick();
    end
    idle();
    // Push onto a full FIFO while its head hits.
    set_pred(2'd3, 22'h35);
    set_res(2'd3, 22'h31);
    tick();
    idle();
    tests++;
    if ({overflow, full, redirect, hit_count} !== {1'b0, 4'b1000, 1'b0, 16'd6}) begin
      failed++;
      $display("FAIL pushpop_hit: got ovf=%b full=%b red=%b hit=%0d, expected ovf=0 full=1000 red=0 hit=6",
               overflow, full, redirect, hit_count);
    end
    // Push while the head mismatches: clear wins.
    set_pred(2'd3, 22'h36);
    set_res(2'd3, 22'h99);
    tick();
    idle();
    tests++;
    if ({redirect, redirect_thread, redirect_address, full, overflow, miss_count} !==
        {1'b1, 2'd3, 22'h99, 4'b0000, 1'b0, 16'd4}) begin
      failed++;
      $display("FAIL pushpop_miss: got red=%b thr=%0d addr=%h full=%b ovf=%b miss=%0d, expected red=1 thr=3 addr=000099 full=0000 ovf=0 miss=4",
               redirect, redirect_thread, redirect_address, full, overflow, miss_count);
    end
    tick();
    set_res(2'd3, 22'h36);
    tick();
    idle();
    tests++;
    if ({redirect, miss_count, hit_count} !== {1'b1, 16'd5, 16'd6}) begin
      failed++;
      $display("FAIL pushpop_discard: got red=%b miss=%0d hit=%0d, expected red=1 miss=5 hit=6",
               redirect, miss_count, hit_count);
    end
    tick();
    // Different threads in the same cycle are independent.
    set_pred(2'd0, 22'h40);
    set_res(2'd1, 22'h41);
    tick();
    idle();
    tests++;
    if ({redirect, redirect_thread, redirect_address, miss_count} !== {1'b1, 2'd1, 22'h41, 16'd6}) begin
      failed++;
      $display("FAIL cross_thread_miss: got red=%b thr=%0d addr=%h miss=%0d, expected red=1 thr=1 addr=000041 miss=6",
               redirect, redirect_thread, redirect_address, miss_count);
    end
    set_res(2'd0, 22'h40);
    tick();
    idle();
    tests++;
    if ({redirect, hit_count} !== {1'b0, 16'd7}) begin
      failed++;
      $display("FAIL cross_thread_hit: got red=%b hit=%0d, expected red=0 hit=7", redirect, hit_count);
    end
  endtask

  task automatic test_empty_stall();
    set_res(2'd0, 22'h3FFFFF);
    tick();
    idle();
    tests++;
    if ({redirect, redirect_thread, redirect_address, miss_count} !== {1'b1, 2'd0, 22'h3FFFFF, 16'd7}) begin
      failed++;
      $display("FAIL empty_resolve: got red=%b thr=%0d addr=%h miss=%0d, expected red=1 thr=0 addr=3fffff miss=7",
               redirect, redirect_thread, redirect_address, miss_count);
    end
    tick();
    stall = 1'b1;
    set_pred(2'd0, 22'h77);
    tick();
    idle();
    set_res(2'd0, 22'h77);
    tick();
    idle();
    tests++;
    if ({redirect, redirect_address, hit_count, miss_count} !== {1'b1, 22'h77, 16'd7, 16'd8}) begin
      failed++;
      $display("FAIL stall_block: got red=%b addr=%h hit=%0d miss=%0d, expected red=1 addr=000077 hit=7 miss=8",
               redirect, redirect_address, hit_count, miss_count);
    end
    tick();
    tests++;
    if ({redirect, redirect_thread, redirect_address} !== {1'b0, 2'd0, 22'h77}) begin
      failed++;
      $display("FAIL redirect_hold: got red=%b thr=%0d addr=%h, expected red=0 thr=0 addr=000077",
               redirect, redirect_thread, redirect_address);
    end
  endtask

  task automatic test_async_reset();
    set_pred(2'd1, 22'h50);
    tick();
    idle();
    set_res(2'd2, 22'h60);
    tick();
    idle();
    tests++;
    if (redirect !== 1'b1) begin
      failed++;
      $display("FAIL pre_reset_redirect: got red=%b, expected 1", redirect);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({redirect, redirect_thread, redirect_address, full, overflow, hit_count, miss_count} !== '0) begin
      failed++;
      $display("FAIL async_reset: got red=%b thr=%0d addr=%h full=%b ovf=%b hit=%0d miss=%0d, expected all 0",
               redirect, redirect_thread, redirect_address, full, overflow, hit_count, miss_count);
    end
    #1 rst = 1'b0;
    // Thread 1 held 0x50 before reset; it must now be empty.
    set_res(2'd1, 22'h50);
    tick();
    idle();
    tests++;
    if ({redirect, redirect_thread, hit_count, miss_count} !== {1'b1, 2'd1, 16'd0, 16'd1}) begin
      failed++;
      $display("FAIL reset_flush: got red=%b thr=%0d hit=%0d miss=%0d, expected red=1 thr=1 hit=0 miss=1",
               redirect, redirect_thread, hit_count, miss_count);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_hit();
    test_mismatch();
    test_full_overflow();
    test_back_to_back();
    test_empty_stall();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/jump_verify.md
# jump_verify

Back-end consumer of the per-thread return-address predictions made by the jump stack. It buffers each thread's predicted `jr` target in a small per-thread FIFO as the prediction leaves pre-align. When that thread's `jr` resolves in execute, the block compares the actual target against the oldest pending prediction. On a mismatch it issues a registered redirect and discards that thread's younger, wrong-path predictions. It also keeps hit/miss statistics.

## Interface
Parameters:
- `ADDRESS_WIDTH`, 22: width of predicted and resolved addresses.
- `DEPTH`, 4: pending predictions per thread; power of two, 2..16. There are always 4 threads.

Ports:
- `i_Clk`  in  1  single clock, rising edge.
- `i_Reset`  in  1  asynchronous, active-high reset.
- `i_Stall`  in  1  while high, prediction enqueue is blocked; resolve is unaffected.
- `i_pred_valid`  in  1  a predicted `jr` target is presented (jump stack `o_valid`).
- `i_pred_thread`  in  2  thread of the prediction.
- `i_pred_address`  in  `ADDRESS_WIDTH`  predicted target (jump stack `o_address`).
- `i_resolve_valid`  in  1  a `jr` resolved in execute this cycle.
- `i_resolve_thread`  in  2  thread of the resolving `jr`.
- `i_resolve_target`  in  `ADDRESS_WIDTH`  actual target.
- `o_redirect`  out  1  one-cycle pulse: front end must refetch.
- `o_redirect_thread`  out  2  thread to redirect.
- `o_redirect_address`  out  `ADDRESS_WIDTH`  correct target.
- `o_full`  out  4  bit t set when thread t holds `DEPTH` entries.
- `o_overflow`  out  1  one-cycle pulse: a prediction was dropped because its FIFO was full.
- `o_hit_count`  out  16  saturating count of correct predictions.
- `o_miss_count`  out  16  saturating count of mispredictions.

## Operation
- Each thread has a FIFO with a head pointer and a tail pointer (log2(`DEPTH`) bits, wrap modulo `DEPTH`) and an occupancy count (log2(`DEPTH`)+1 bits).
- Each thread also has a two-state FSM: ACTIVE and SQUASH.
- Reset value of every output and all state is 0. All FSMs reset to ACTIVE. Reset may assert mid-operation; it clears everything immediately, including a pending `o_redirect`.
- **Enqueue:** happens when `i_pred_valid & ~i_Stall` and thread `i_pred_thread` is ACTIVE.
  - If that FIFO is not full: write `i_pred_address` at the tail and increment.
  - If it is full: drop the entry, leave the FIFO unchanged, and pulse `o_overflow` next cycle.
  - A prediction for a SQUASH thread is discarded silently; no overflow is flagged.
- **Resolve:** happens when `i_resolve_valid`, for thread r = `i_resolve_thread`.
  - Hit: FIFO r is non-empty and the head equals `i_resolve_target`. Pop the head and increment `o_hit_count`.
  - Miss: FIFO r is empty, or the head differs. Then:
    - clear FIFO r (pointers and count to 0);
    - increment `o_miss_count`;
    - next cycle, drive `o_redirect`=1, `o_redirect_thread`=r, `o_redirect_address`=`i_resolve_target`;
    - FSM r goes ACTIVE -> SQUASH.
- **SQUASH -> ACTIVE:** after exactly one cycle in SQUASH, unconditionally. This covers the one-cycle latency of the jump stack: a prediction presented in the redirect cycle is wrong-path.
- **Simultaneous enqueue and resolve, same thread:**
  - On a hit, pop and push both occur. Occupancy is unchanged, and a full FIFO accepts the new entry with no overflow.
  - On a miss, the clear wins and the incoming prediction is discarded.
- **Simultaneous events, different threads:** fully independent.
- Counters saturate at 16'hFFFF and do not wrap.
- `o_redirect_thread` and `o_redirect_address` hold their last values while `o_redirect`=0.

## Timing
- Enqueue is visible to a resolve in the next cycle or later. A same-cycle enqueue and resolve compare against the pre-existing head.
- Redirect latency: 1 cycle from the resolve cycle, on a registered output.
- `o_full`, `o_hit_count` and `o_miss_count` are registered and reflect the state after the previous edge.
- `o_overflow` pulses 1 cycle after the dropped enqueue.
- Throughput: one enqueue and one resolve per cycle, sustained.

## Test plan
- **Basic hit.** Reset, then enqueue thread 0 address 0x00100 and resolve thread 0 target 0x00100 the following cycle. Required: no redirect, `o_hit_count`=1, thread 0 empty.
- **Mismatch.** Enqueue thread 2 with 0x0A, 0x0B, 0x0C; then resolve thread 2 target 0x0F. Required: next cycle `o_redirect`=1, thread=2, address=0x0F; `o_miss_count`=1; thread 2 empty. A prediction for thread 2 presented in the redirect cycle is dropped.
- **Full and overflow.** Enqueue 5 entries to thread 1 with `DEPTH`=4. Required: `o_full`=4'b0010 and one `o_overflow` pulse. Then resolve against the first 4 addresses in order: 4 hits, no redirect.
- **Simultaneous same-thread push/pop while full.** Thread 3 is full and its head matches. Required: no overflow, occupancy stays 4. Repeat with a head mismatch: thread 3 is empty afterwards, the new entry is discarded, and `o_redirect` fires.
- **Empty-queue resolve and stall.** Resolve thread 0 with an empty FIFO and target 0x3FFFFF. Required: redirect to 0x3FFFFF. Separately, a prediction presented with `i_Stall`=1 is not enqueued.
- **Async reset mid-redirect.** Assert `i_Reset` in the cycle `o_redirect` is high. Required: all outputs are 0 immediately, counters are 0, and all FIFOs are empty.
